// File: rtl/event_queue_encoder_pkg.sv
// Shared definitions for the event queue encoder: selection modes and
// the pending-count width formula.
package event_queue_encoder_pkg;

  localparam int EVQ_MODE_FIXED = 0;
  localparam int EVQ_MODE_RR    = 1;

  // Width needed to hold a popcount of w bits (0..w inclusive)
  function automatic int evq_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/event_queue_encoder_prio_find.sv
// Rotating find-first-set: returns the first set bit of vec at or after
// ptr, wrapping past W-1 back to 0. With ptr tied to 0 it is a plain
// lowest-set-bit finder.
module prio_find
  import event_queue_encoder_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // Scan offsets from the far end so the smallest offset from ptr wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = W - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(W)) pos = pos - (IW+1)'(W);
      if (vec[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/event_queue_encoder.sv
// Registered, handshaked event encoder. Sticky event bits collect in a
// pending register; a one-entry output stage hands one source index at a
// time to the consumer, in fixed-priority or round-robin order.
module event_queue_encoder
  import event_queue_encoder_pkg::*;
#(
  parameter int VECT_W  = 16,
  parameter int BIN_W   = $clog2(VECT_W),
  parameter int RR_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [VECT_W-1:0]                ev,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIN_W-1:0]                 out_idx,
  output logic [evq_cnt_w(VECT_W)-1:0]     pend_cnt,
  output logic                             lost
);

  localparam int CNT_W = evq_cnt_w(VECT_W);

  logic [VECT_W-1:0] pending_q, pending_d;
  logic              out_valid_q, out_valid_d;
  logic [BIN_W-1:0]  out_idx_q, out_idx_d;
  logic [BIN_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic              lost_q, lost_d;

  logic              load;
  logic              found;
  logic [BIN_W-1:0]  sel;
  logic [BIN_W-1:0]  find_ptr;
  logic [VECT_W-1:0] load_mask;

  // Fixed-priority mode always scans from bit 0
  assign find_ptr = (RR_MODE == EVQ_MODE_RR) ? rr_ptr_q : '0;

  prio_find #(.W(VECT_W), .IW(BIN_W)) u_find (
    .vec   (pending_q),
    .ptr   (find_ptr),
    .found (found),
    .idx   (sel)
  );

  // Next-state for pending, output stage, rr pointer, count and lost flag
  always_comb begin
    load        = found && (!out_valid_q || out_ready);
    load_mask   = '0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      load_mask[sel] = 1'b1;
      out_valid_d    = 1'b1;
      out_idx_d      = sel;
      rr_ptr_d       = (sel == BIN_W'(VECT_W - 1)) ? '0 : sel + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new event re-arms its bit even if that bit is being loaded now
    pending_d  = (pending_q & ~load_mask) | ev;
    lost_d     = |(ev & pending_q & ~load_mask);
    pend_cnt_d = '0;
    for (int i = 0; i < VECT_W; i++) begin
      pend_cnt_d = pend_cnt_d + {{(CNT_W-1){1'b0}}, pending_d[i]};
    end
  end

  // State registers; flush clears exactly what reset clears
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
      pend_cnt_q  <= '0;
      lost_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_cnt_q  <= pend_cnt_d;
      lost_q      <= lost_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend_cnt  = pend_cnt_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_event_queue_encoder.sv
// Bench for event_queue_encoder: one fixed-priority and one round-robin
// instance, expected index streams queued per instance and popped on
// each observed handshake.
module tb_event_queue_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] f_ev, r_ev;
  logic        f_ready, r_ready;
  logic        f_valid, r_valid;
  logic [3:0]  f_idx, r_idx;
  logic [4:0]  f_cnt, r_cnt;
  logic        f_lost, r_lost;

  int checks = 0;
  int errors = 0;
  int q_fix[$];
  int q_rr[$];

  always #5 clk = ~clk;

  event_queue_encoder #(.VECT_W(16), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .flush(flush), .ev(f_ev),
    .out_valid(f_valid), .out_ready(f_ready), .out_idx(f_idx),
    .pend_cnt(f_cnt), .lost(f_lost)
  );

  event_queue_encoder #(.VECT_W(16), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .ev(r_ev),
    .out_valid(r_valid), .out_ready(r_ready), .out_idx(r_idx),
    .pend_cnt(r_cnt), .lost(r_lost)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted transfer must match the next queued index
  always @(negedge clk) begin
    if (!rst && f_valid && f_ready) begin
      if (q_fix.size() == 0) chk("fix_extra_idx", 32'(f_idx), 32'hFFFF);
      else chk("fix_idx", 32'(f_idx), 32'(q_fix.pop_front()));
    end
    if (!rst && r_valid && r_ready) begin
      if (q_rr.size() == 0) chk("rr_extra_idx", 32'(r_idx), 32'hFFFF);
      else chk("rr_idx", 32'(r_idx), 32'(q_rr.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    f_ev = 16'hFFFF; r_ev = 16'hFFFF;
    f_ready = 1'b0; r_ready = 1'b0;

    // Reset with events asserted: all dropped
    repeat (2) tick();
    rst = 1'b0; f_ev = '0; r_ev = '0;
    chk("rst_valid", 32'(f_valid), 0);
    chk("rst_cnt", 32'(f_cnt), 0);
    chk("rst_lost", 32'(f_lost), 0);
    tick();
    chk("rst_valid_after", 32'({f_valid, r_valid}), 0);
    chk("rst_cnt_after", 32'(f_cnt), 0);

    // Fixed priority drain of 8421
    f_ready = 1'b1;
    q_fix.push_back(0); q_fix.push_back(5); q_fix.push_back(10); q_fix.push_back(15);
    f_ev = 16'h8421;
    tick();
    f_ev = '0;
    chk("fp_cnt_capture", 32'(f_cnt), 4);
    chk("fp_valid_pre", 32'(f_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fp_valid", 32'(f_valid), 1);
      chk("fp_cnt", 32'(f_cnt), 32'(3 - i));
    end
    tick();
    chk("fp_valid_drop", 32'(f_valid), 0);
    chk("fp_lost_quiet", 32'(f_lost), 0);

    // Backpressure: index 1 held, then 1, 2
    f_ready = 1'b0;
    q_fix.push_back(1); q_fix.push_back(2);
    f_ev = 16'h0006;
    tick();
    f_ev = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", 32'({f_valid, f_idx}), 32'h11);
    end
    chk("bp_cnt", 32'(f_cnt), 1);
    f_ready = 1'b1;
    tick();
    chk("bp_second", 32'({f_valid, f_idx}), 32'h12);
    tick();
    chk("bp_drop", 32'(f_valid), 0);

    // Lost pulse on a re-hit pending bit, then set-wins on the load cycle
    f_ready = 1'b0;
    q_fix.push_back(0); q_fix.push_back(3); q_fix.push_back(3);
    f_ev = 16'h0009;
    tick();
    f_ev = '0;
    tick();
    chk("lost_busy_idx", 32'({f_valid, f_idx}), 32'h10);
    chk("lost_cnt_pre", 32'(f_cnt), 1);
    f_ev = 16'h0008;
    tick();
    f_ev = '0;
    chk("lost_pulse", 32'(f_lost), 1);
    chk("lost_cnt_same", 32'(f_cnt), 1);
    tick();
    chk("lost_once", 32'(f_lost), 0);
    f_ready = 1'b1;
    f_ev = 16'h0008;
    tick();
    f_ev = '0;
    chk("setwin_nolost", 32'(f_lost), 0);
    chk("setwin_cnt", 32'(f_cnt), 1);
    chk("setwin_idx", 32'({f_valid, f_idx}), 32'h13);
    tick();
    chk("setwin_again", 32'({f_valid, f_idx}), 32'h13);
    chk("setwin_cnt0", 32'(f_cnt), 0);
    tick();
    chk("setwin_drop", 32'(f_valid), 0);

    // Flush with an output held and F0 pending
    f_ready = 1'b0;
    f_ev = 16'h00F1;
    tick();
    f_ev = '0;
    tick();
    chk("fl_pre", 32'({f_valid, f_idx}), 32'h10);
    chk("fl_pre_cnt", 32'(f_cnt), 4);
    flush = 1'b1; f_ev = 16'h0001;
    tick();
    flush = 1'b0; f_ev = '0; f_ready = 1'b1;
    chk("fl_valid", 32'(f_valid), 0);
    chk("fl_cnt", 32'(f_cnt), 0);
    chk("fl_idx", 32'(f_idx), 0);
    repeat (3) tick();
    chk("fl_no_emit", 32'(f_valid), 0);

    // Round-robin: 5, then 0 (wrap from ptr 6), then 5; then 6 before 0
    r_ready = 1'b1;
    q_rr.push_back(5); q_rr.push_back(0); q_rr.push_back(5);
    q_rr.push_back(6); q_rr.push_back(0);
    r_ev = 16'h0020;
    tick();
    r_ev = '0;
    tick();
    chk("rr_first", 32'({r_valid, r_idx}), 32'h15);
    r_ev = 16'h0021;
    tick();
    r_ev = '0;
    chk("rr_cnt2", 32'(r_cnt), 2);
    tick();
    chk("rr_wrap0", 32'({r_valid, r_idx}), 32'h10);
    tick();
    chk("rr_then5", 32'({r_valid, r_idx}), 32'h15);
    tick();
    chk("rr_drop", 32'(r_valid), 0);
    r_ev = 16'h0041;
    tick();
    r_ev = '0;
    tick();
    chk("rr_ptr6", 32'({r_valid, r_idx}), 32'h16);
    tick();
    chk("rr_ptr_wrap", 32'({r_valid, r_idx}), 32'h10);
    repeat (2) tick();

    chk("fix_q_left", 32'(q_fix.size()), 0);
    chk("rr_q_left", 32'(q_rr.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
